// File: rtl/deswitch_2cross2.sv
// Receive-side un-cross for the 2x2 cross switch: restores lane order using the sel tag and buffers each lane in its own FIFO.
// Optional swap statistics counter enabled by defining DESWITCH_SWAP_STATS_EN.
module deswitch_2cross2 #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           io_in1,
    input  logic [WIDTH-1:0]           io_in2,
    input  logic                       io_in_sel,
    input  logic                       io_in_valid,
    output logic                       io_in_ready,
    output logic [WIDTH-1:0]           io_out1,
    output logic                       io_out1_valid,
    input  logic                       io_out1_ready,
    output logic [WIDTH-1:0]           io_out2,
    output logic                       io_out2_valid,
    input  logic                       io_out2_ready,
`ifdef DESWITCH_SWAP_STATS_EN
    input  logic                       io_stats_clear,
    output logic [15:0]                io_swap_count,
`endif
    output logic [$clog2(DEPTH):0]     io_count1,
    output logic [$clog2(DEPTH):0]     io_count2
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0]    wr_q [2];
    logic [CW-1:0]    wr_d [2];
    logic [CW-1:0]    rd_q [2];
    logic [CW-1:0]    rd_d [2];
    logic [WIDTH-1:0] mem_q [2][DEPTH];
    logic [WIDTH-1:0] lane_din [2];
    logic [WIDTH-1:0] head [2];
    logic [CW-1:0]    count [2];
    logic [1:0]       empty;
    logic [1:0]       full;
    logic [1:0]       pop;
    logic [1:0]       out_ready;
    logic             push;

    assign out_ready = {io_out2_ready, io_out1_ready};

    // Ready depends only on registered pointers, so a pop never frees a slot in the same cycle.
    assign io_in_ready = !(|full);
    assign push        = io_in_valid && io_in_ready;

    always_comb begin
        lane_din[0] = io_in_sel ? io_in2 : io_in1;
        lane_din[1] = io_in_sel ? io_in1 : io_in2;
    end

    always_comb begin
        for (int l = 0; l < 2; l++) begin
            empty[l] = (wr_q[l] == rd_q[l]);
            full[l]  = (wr_q[l][AW-1:0] == rd_q[l][AW-1:0]) && (wr_q[l][AW] != rd_q[l][AW]);
            pop[l]   = !empty[l] && out_ready[l];
            wr_d[l]  = wr_q[l] + CW'(push);
            rd_d[l]  = rd_q[l] + CW'(pop[l]);
            count[l] = wr_q[l] - rd_q[l];
            head[l]  = empty[l] ? '0 : mem_q[l][rd_q[l][AW-1:0]];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int l = 0; l < 2; l++) begin
                wr_q[l] <= '0;
                rd_q[l] <= '0;
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                wr_q[l] <= wr_d[l];
                rd_q[l] <= rd_d[l];
            end
        end
    end

    // Storage needs no reset: contents are only visible through non-empty pointers.
    always_ff @(posedge clock) begin
        if (push) begin
            for (int l = 0; l < 2; l++) begin
                mem_q[l][wr_q[l][AW-1:0]] <= lane_din[l];
            end
        end
    end

    assign io_out1       = head[0];
    assign io_out2       = head[1];
    assign io_out1_valid = !empty[0];
    assign io_out2_valid = !empty[1];
    assign io_count1     = count[0];
    assign io_count2     = count[1];

`ifdef DESWITCH_SWAP_STATS_EN
    logic [15:0] swap_cnt_q;
    logic [15:0] swap_cnt_d;

    always_comb begin
        swap_cnt_d = swap_cnt_q;
        if (io_stats_clear) begin
            swap_cnt_d = '0;
        end else if (push && io_in_sel && (swap_cnt_q != 16'hFFFF)) begin
            swap_cnt_d = swap_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            swap_cnt_q <= '0;
        end else begin
            swap_cnt_q <= swap_cnt_d;
        end
    end

    assign io_swap_count = swap_cnt_q;
`endif

endmodule

// File: doc/deswitch_2cross2.md
Name: deswitch_2cross2

Overview:
- Receive-side counterpart of the 2x2 cross switch.
- Accepts a crossed lane pair together with the sel tag that crossed it, un-crosses the pair, and buffers each restored lane in its own FIFO.
- Each restored lane is handed to its consumer with an independent valid/ready handshake.
- Sits at the far end of a swapped link; decouples the link from the two consumers.

Parameters:
- WIDTH, 32, data width of each lane.
- DEPTH, 4, entries per lane FIFO; power of two, >= 2.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- io_in1  input  WIDTH  crossed lane 1 data.
- io_in2  input  WIDTH  crossed lane 2 data.
- io_in_sel  input  1  swap tag for the current input beat; 1 = lanes were swapped.
- io_in_valid  input  1  input beat present (both lanes plus tag).
- io_in_ready  output  1  block can accept a beat.
- io_out1  output  WIDTH  restored lane 1 data.
- io_out1_valid  output  1  lane 1 FIFO non-empty.
- io_out1_ready  input  1  lane 1 consumer accepts.
- io_out2  output  WIDTH  restored lane 2 data.
- io_out2_valid  output  1  lane 2 FIFO non-empty.
- io_out2_ready  input  1  lane 2 consumer accepts.
- io_count1  output  clog2(DEPTH)+1  lane 1 occupancy.
- io_count2  output  clog2(DEPTH)+1  lane 2 occupancy.

Behaviour:
- Reset (reset low, asynchronous): all pointers, counts, valids and io_in_ready-driving state cleared. Outputs go to io_out*=0, io_out*_valid=0, io_count*=0, io_in_ready=1 (after release).
- Un-cross mapping at push:
  - lane1 entry = io_in_sel ? io_in2 : io_in1
  - lane2 entry = io_in_sel ? io_in1 : io_in2
  - The mapping is an involution, so a swapped beat is exactly restored.
- Input handshake: beat accepted on the rising edge where io_in_valid && io_in_ready. Both lanes are pushed together; never one without the other.
- io_in_ready = !(full1 || full2), decoded from registered state only. It has no combinational path from io_out*_ready.
- Full lane with a pop in the same cycle: io_in_ready stays 0 that cycle. The freed slot becomes visible on the next cycle.
- Output handshake, per lane independent: pop on the rising edge where io_outX_valid && io_outX_ready.
  - Data is held stable while valid && !ready.
  - io_outX = head entry when valid, else 0.
- Latency: a beat accepted at edge N is visible with io_outX_valid=1 after edge N, i.e. in cycle N+1. No same-cycle bypass.
- FIFO per lane:
  - Read/write pointers are clog2(DEPTH)+1 bits; wrap modulo 2*DEPTH.
  - Empty when pointers are equal; full when the index bits are equal and the MSB differs.
  - count = wr - rd, range 0..DEPTH.
- Simultaneous push and pop on a non-full, non-empty lane: count unchanged; ordering preserved.
- Push onto an empty lane while the consumer is ready: no pop that cycle, because valid was 0.
- io_in_valid while io_in_ready=0: beat not taken; the sender holds it. The block ignores io_in_sel and data that cycle.
- Lanes drain independently. A stalled lane 2 eventually blocks input through full2, while lane 1 continues draining.
- Reset asserted mid-operation: all contents discarded immediately; no partial state survives.

Optional Feature:
- Macro: DESWITCH_SWAP_STATS_EN.
- Defined:
  - Adds output io_swap_count (16 bits): number of accepted beats with io_in_sel=1.
  - Saturates at 0xFFFF; cleared by reset.
  - Adds input io_stats_clear (1 bit): synchronous clear that takes priority over increment in the same cycle.
- Undefined: both ports and the counter are absent. All other behaviour is identical.

Test Plan:
- Reset then idle: io_in_ready=1, both out valids 0, io_out1=io_out2=0, counts 0.
- Single beat, sel=1, in1=0xAAAA0001, in2=0xBBBB0002, both outs ready: next cycle io_out1=0xBBBB0002, io_out2=0xAAAA0001, both valid for exactly one cycle.
- Fill, DEPTH=4, outputs not ready: push beats 1..4 with sel alternating 0/1. io_in_ready drops after the 4th accept and count1=count2=4. The 5th beat is held. Release lane 1 only: lane 1 drains in order 4 beats while io_in_ready stays 0 until lane 2 pops.
- Full with simultaneous pop: lane 1 and lane 2 full, both outs ready, io_in_valid=1. No accept on that edge; accept on the following edge. Counts read 3 then 3.
- Wrap-around: stream 20 beats with continuous valid/ready and random sel. Outputs match a reference un-cross model in order; pointers wrap cleanly across 2*DEPTH.
- Async reset mid-stream with 3 entries queued: valids drop without waiting for a clock edge. After release, count=0 and the next beat appears one cycle after acceptance. With DESWITCH_SWAP_STATS_EN defined: 5 sel=1 beats give io_swap_count=5; clear plus a swapped beat in the same cycle gives 0.
